rr_onehot_arbiter: RTL
======================

# rr_onehot_arbiter

Registered round-robin arbiter producing the one-hot select consumed by the one-hot data mux in the issue/writeback paths. Takes up to REQ_NUM request lines, picks one with rotating priority, and holds a stable one-hot grant under a valid/ready handshake until the downstream stage accepts it. The grant bus is always zero or exactly one-hot, so a one-hot mux fed from it never sees a multi-hot select.

## Interface

- REQ_NUM, 16, number of requesters (≥2)
- IDX_W, $clog2(REQ_NUM), width of encoded grant index

- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; dominates every other input
- req  in  REQ_NUM  per-requester request, level-sensitive
- flush  in  1  squash: drop the pending grant without handshake
- grant_ready  in  1  downstream accepts the current grant this cycle
- grant_valid  out  1  grant_onehot/grant_idx are meaningful
- grant_onehot  out  REQ_NUM  registered one-hot grant; all-zero when grant_valid=0
- grant_idx  out  IDX_W  binary index of the set bit of grant_onehot; 0 when idle

## Operation

- State: 2-state FSM IDLE (grant_valid=0) / HOLD (grant_valid=1), plus priority pointer ptr[IDX_W-1:0].
- Arbitration: winner is the first set bit of req scanning ptr, ptr+1, …, REQ_NUM-1, 0, …, ptr-1 (index wraps modulo REQ_NUM; no power-of-two assumption).
- Handshake: accept = grant_valid & grant_ready.
- IDLE: if req≠0 and !flush → load winner into grant_onehot/grant_idx, go HOLD. Else stay IDLE, outputs zero.
- HOLD, accept=0, flush=0: outputs frozen regardless of req changes (grant is sticky even if the granted req drops).
- HOLD, accept=1: ptr ← (grant_idx+1) mod REQ_NUM. Re-arbitrate the same cycle on current req using the new ptr; if req≠0 and !flush stay HOLD with new winner, else go IDLE. req in the accept cycle is taken as the requester's next request (just-granted requester may win again only if it is the sole requester).
- HOLD, flush=1, accept=0: go IDLE, ptr unchanged.
- HOLD, flush=1, accept=1: handshake completes (ptr advances), no new grant; go IDLE.
- IDLE, flush=1: stay IDLE (flush blocks new grant that cycle).
- Reset: state IDLE, ptr=0, grant_valid=0, grant_onehot=0, grant_idx=0.
- Invariant (assert): grant_valid=0 ⇒ grant_onehot=0; grant_valid=1 ⇒ $onehot(grant_onehot) and grant_onehot==1<<grant_idx.

## Timing

- Request-to-grant latency: 1 cycle (req sampled at edge t, grant visible after edge t).
- Throughput: one accepted grant per cycle with grant_ready held high and req nonzero.
- Outputs are pure flop outputs; no combinational path from any input to any output.
- grant_ready may be asserted while grant_valid=0; ignored.
- Starvation bound: a continuously asserted req is granted within REQ_NUM accepts.
- Reset asserted mid-HOLD: outputs zero after that edge; no handshake counted.

## Test plan

- REQ_NUM=4, reset then req=0101, ready=1 held → grant_onehot 0001, 0100, 0001, 0100 on successive cycles; grant_idx 0,2,0,2.
- req=0110, ready=0 for 3 cycles → grant 0010 stable all 3 cycles even with req changed to 0100 mid-hold; ready=1 one cycle → next cycle grant 0100, idx 2.
- Wrap: after accepting idx 2 (ptr=3), req=1001, ready=1 → 1000 then 0001; after accepting idx 3 ptr=0.
- Flush in HOLD with ready=0, grant 0010, req=0010 held → next cycle valid=0, onehot=0000; cycle after, grant 0010 again (ptr unchanged).
- Flush and accept same cycle, grant 0001, req=0011 → next cycle valid=0; cycle after grant 0010 (ptr advanced to 1).
- Reset asserted during HOLD with req=1111 → next cycle all outputs zero; after release, first grant 0001 (ptr=0); one-hot invariant checked every cycle under random req/ready/flush.

Source files
------------

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter
// Registered round-robin arbiter that drives the select of a one-hot data mux.
// A grant is held stable under a valid/ready handshake until it is accepted
// or flushed. After an accept, the requester just served gets the lowest
// priority. The grant bus is always either all-zero or exactly one-hot.

module rr_onehot_arbiter #(
    parameter int REQ_NUM = 16,
    parameter int IDX_W   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [REQ_NUM-1:0] req,
    input  logic               flush,
    input  logic               grant_ready,
    output logic               grant_valid,
    output logic [REQ_NUM-1:0] grant_onehot,
    output logic [IDX_W-1:0]   grant_idx
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [REQ_NUM-1:0] onehot_q, onehot_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic               accept;
    logic [IDX_W-1:0]   idx_inc;
    logic [IDX_W-1:0]   arb_ptr;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic               load_grant;

    // The handshake can only complete while a grant is actually presented.
    assign accept = (state_q == HOLD) && grant_ready;

    // Successor of the current grant index. The explicit wrap supports
    // REQ_NUM values that are not a power of two.
    assign idx_inc = (idx_q == IDX_W'(REQ_NUM - 1)) ? '0 : idx_q + 1'b1;

    // On an accept, re-arbitrate in the same cycle from the advanced pointer.
    // Without this, the requester just served could win again straight away.
    assign arb_ptr = accept ? idx_inc : ptr_q;

    // Find the first set request, scanning from arb_ptr upward with wrap.
    always_comb begin
        int pos;
        // NOTE: every variable assigned here gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        pos       = 0;
        for (int i = 0; i < REQ_NUM; i++) begin
            pos = int'(arb_ptr) + i;
            if (pos >= REQ_NUM) begin
                pos = pos - REQ_NUM;
            end
            if (!win_found && req[pos[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = pos[IDX_W-1:0];
            end
        end
    end

    // Next-state logic: IDLE <-> HOLD, with flush dominating any new grant.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (win_found && !flush) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (accept) begin
                    state_d = win_found ? HOLD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next grant registers and pointer. A grant is loaded on entry to HOLD
    // and on an accept that stays in HOLD. Otherwise HOLD freezes the grant
    // and IDLE clears it.
    always_comb begin
        ptr_d      = ptr_q;
        onehot_d   = onehot_q;
        idx_d      = idx_q;
        load_grant = (state_d == HOLD) && ((state_q == IDLE) || accept);

        if (accept) begin
            ptr_d = idx_inc;
        end

        if (load_grant) begin
            onehot_d          = '0;
            onehot_d[win_idx] = 1'b1;
            idx_d             = win_idx;
        end else if (state_d == IDLE) begin
            onehot_d = '0;
            idx_d    = '0;
        end
    end

    // State, pointer and grant registers. Reset is synchronous and wins
    // over every other input.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments, so all
        // registers update together from values sampled before the edge.
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            onehot_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            onehot_q <= onehot_d;
            idx_q    <= idx_d;
        end
    end

    // All outputs come straight from registers.
    assign grant_valid  = (state_q == HOLD);
    assign grant_onehot = onehot_q;
    assign grant_idx    = idx_q;

endmodule
